// File: rtl/warp_fetch_scheduler_pkg.sv
// Shared GPGPU front-end parameters for the warp fetch scheduler.
//   NUM_WARP     : number of hardware warps
//   NUM_WARP_LOG : width of a warp id
//   CREDITS      : fetch packets a warp may have between fetch and decode retire
//   CREDIT_W     : width of a per-warp credit counter (holds 0..CREDITS)
package warp_fetch_scheduler_pkg;

    localparam int NUM_WARP     = 8;
    localparam int NUM_WARP_LOG = 3;
    localparam int CREDITS      = 2;
    localparam int CREDIT_W     = 2;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);

    typedef logic [NUM_WARP_LOG-1:0] warpId_t;
    typedef logic [CREDIT_W-1:0]     credit_t;

endpackage

// File: rtl/warp_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      in  : request vector, one bit per warp
//   ptr      in  : highest-priority warp id this cycle
//   grant    out : one-hot grant
//   grantId  out : encoded id of the granted warp
//   anyGrant out : at least one request present
// The request vector is duplicated so that a plain lowest-bit search over the
// upper portion (from ptr upward) naturally wraps back to warp 0.
module rr_arbiter
    import warp_fetch_scheduler_pkg::*;
(
    input  logic [NUM_WARP-1:0] req,
    input  warpId_t             ptr,
    output logic [NUM_WARP-1:0] grant,
    output warpId_t             grantId,
    output logic                anyGrant
);

    localparam int DW = 2 * NUM_WARP;

    logic [DW-1:0] dbl;
    logic [DW-1:0] below;
    logic [DW-1:0] masked;

    always_comb begin
        dbl      = {req, req};
        below    = (DW'(1) << ptr) - DW'(1);
        masked   = dbl & ~below;
        grantId  = '0;
        anyGrant = 1'b0;
        // Descending scan: the last hit is the lowest set bit at or above ptr.
        for (int i = DW - 1; i >= 0; i--) begin
            if (masked[i]) begin
                grantId  = NUM_WARP_LOG'(i % NUM_WARP);
                anyGrant = 1'b1;
            end
        end
        grant = anyGrant ? (NUM_WARP'(1) << grantId) : '0;
    end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Warp fetch scheduler: picks one eligible warp per cycle in round-robin order
// and registers it as the fetch request. Tracks per-warp instruction-buffer
// credits, branch/barrier block state and flush recovery.
//   clk, reset     : clock, synchronous active-high reset
//   warpActive_i   : warp launched and not finished
//   stall_i        : downstream stall; holds grant, pointer and credits
//   creditRet_i    : decode consumed one packet of warp creditWarp_i
//   block_i        : block warp blockWarp_i until it is flushed
//   flush_i        : redirect of flushWarp_i; restores credits and unblocks
//   fetchValid_o   : registered fetch request valid
//   fetchWarp_o    : registered granted warp id
//   creditErr_o    : sticky flag, credit returned to a warp already full
module warp_fetch_scheduler
    import warp_fetch_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_WARP-1:0] warpActive_i,
    input  logic                stall_i,
    input  logic                creditRet_i,
    input  warpId_t             creditWarp_i,
    input  logic                block_i,
    input  warpId_t             blockWarp_i,
    input  logic                flush_i,
    input  warpId_t             flushWarp_i,
    output logic                fetchValid_o,
    output warpId_t             fetchWarp_o,
    output logic                creditErr_o
);

    // Saturating credit update; simultaneous issue and return cancel out.
    function automatic credit_t creditNext(input credit_t cur, input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return (cur == CREDIT_MAX) ? cur : cur + 1'b1;
            2'b01:   return cur - 1'b1;
            default: return cur;
        endcase
    endfunction

    credit_t             credit [NUM_WARP];
    logic [NUM_WARP-1:0] blocked;
    logic [NUM_WARP-1:0] eligible;
    logic [NUM_WARP-1:0] grantOneHot;
    warpId_t             rrPtr;
    warpId_t             grantId;
    logic                anyGrant;
    logic                issue;
    logic                retErr;
    logic                fetchValid_p1;
    warpId_t             fetchWarp_p1;
    logic                creditErr;

    always_comb begin
        for (int w = 0; w < NUM_WARP; w++) begin
            eligible[w] = warpActive_i[w] & (credit[w] != '0) & ~blocked[w];
        end
    end

    rr_arbiter uArb (
        .req      (eligible),
        .ptr      (rrPtr),
        .grant    (grantOneHot),
        .grantId  (grantId),
        .anyGrant (anyGrant)
    );

    assign issue = anyGrant & ~stall_i;

    // A return is bogus when the warp already holds all credits, unless a
    // flush of that warp overrides it this cycle.
    assign retErr = creditRet_i & (credit[creditWarp_i] == CREDIT_MAX)
                  & ~(flush_i & (flushWarp_i == creditWarp_i));

    // ---- stage p1: registered grant and scheduler state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchValid_p1 <= 1'b0;
            fetchWarp_p1  <= '0;
            rrPtr         <= '0;
        end else if (!stall_i) begin
            fetchValid_p1 <= anyGrant;
            if (anyGrant) begin
                fetchWarp_p1 <= grantId;
                rrPtr        <= grantId + 1'b1;
            end
        end else if (flush_i && fetchValid_p1 && (flushWarp_i == fetchWarp_p1)) begin
            // Held request belongs to a flushed warp: drop it.
            fetchValid_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                credit[w] <= CREDIT_MAX;
            end
            blocked   <= '0;
            creditErr <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARP; w++) begin
                if (flush_i && (flushWarp_i == NUM_WARP_LOG'(w))) begin
                    credit[w]  <= CREDIT_MAX;
                    blocked[w] <= 1'b0;
                end else begin
                    credit[w] <= creditNext(credit[w],
                                            creditRet_i && (creditWarp_i == NUM_WARP_LOG'(w)),
                                            issue && grantOneHot[w]);
                    if (block_i && (blockWarp_i == NUM_WARP_LOG'(w))) begin
                        blocked[w] <= 1'b1;
                    end
                end
            end
            if (retErr) begin
                creditErr <= 1'b1;
            end
        end
    end

    assign fetchValid_o = fetchValid_p1;
    assign fetchWarp_o  = fetchWarp_p1;
    assign creditErr_o  = creditErr;

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed and randomized bench for warp_fetch_scheduler with a reference
// model expressed as per-warp integer credits, block flags and a modular scan.
module tb_warp_fetch_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] warpActive;
    logic       stall;
    logic       creditRet;
    logic [2:0] creditWarp;
    logic       block;
    logic [2:0] blockWarp;
    logic       flush;
    logic [2:0] flushWarp;
    logic       fetchValid_o;
    logic [2:0] fetchWarp_o;
    logic       creditErr_o;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int       mCred [8];
    bit       mBlk  [8];
    int       mPtr;
    bit       mValid;
    logic [2:0] mWarp;
    bit       mErr;

    always #5 clk = ~clk;

    warp_fetch_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .warpActive_i (warpActive),
        .stall_i      (stall),
        .creditRet_i  (creditRet),
        .creditWarp_i (creditWarp),
        .block_i      (block),
        .blockWarp_i  (blockWarp),
        .flush_i      (flush),
        .flushWarp_i  (flushWarp),
        .fetchValid_o (fetchValid_o),
        .fetchWarp_o  (fetchWarp_o),
        .creditErr_o  (creditErr_o)
    );

    task automatic idleInputs();
        stall = 0; creditRet = 0; creditWarp = 0; block = 0; blockWarp = 0;
        flush = 0; flushWarp = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        int g;
        int c;
        bit inc;
        bit dec;
        if (reset) begin
            for (int w = 0; w < 8; w++) begin mCred[w] = 2; mBlk[w] = 0; end
            mPtr = 0; mValid = 0; mWarp = 0; mErr = 0;
            return;
        end
        g = -1;
        if (!stall) begin
            for (int k = 0; k < 8; k++) begin
                int w;
                w = (mPtr + k) % 8;
                if (warpActive[w] && mCred[w] > 0 && !mBlk[w]) begin g = w; break; end
            end
        end
        if (creditRet && !(flush && flushWarp == creditWarp) && mCred[creditWarp] == 2) mErr = 1;
        for (int w = 0; w < 8; w++) begin
            if (flush && flushWarp == w) begin
                mCred[w] = 2; mBlk[w] = 0;
            end else begin
                inc = creditRet && creditWarp == w;
                dec = (g == w);
                c = mCred[w] - int'(dec) + int'(inc);
                if (c > 2) c = 2;
                mCred[w] = c;
                if (block && blockWarp == w) mBlk[w] = 1;
            end
        end
        if (!stall) begin
            mValid = (g >= 0);
            if (g >= 0) begin mWarp = 3'(g); mPtr = (g + 1) % 8; end
        end else if (flush && mValid && flushWarp == mWarp) begin
            mValid = 0;
        end
    endtask

    task automatic checkOutputs(string tag);
        tests++;
        assert (fetchValid_o === mValid) else begin
            fails++; $error("FAIL %s fetchValid got %0b want %0b", tag, fetchValid_o, mValid);
        end
        tests++;
        assert (fetchWarp_o === mWarp) else begin
            fails++; $error("FAIL %s fetchWarp got %0d want %0d", tag, fetchWarp_o, mWarp);
        end
        tests++;
        assert (creditErr_o === mErr) else begin
            fails++; $error("FAIL %s creditErr got %0b want %0b", tag, creditErr_o, mErr);
        end
    endtask

    task automatic checkConst(string tag, int got, int want);
        tests++;
        assert (got === want) else begin
            fails++; $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic cyc(string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkOutputs(tag);
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1;
        cyc("reset");
        reset = 0;
    endtask

    initial begin
        bit found;
        reset = 1; warpActive = 8'h00;
        idleInputs();
        #1;

        // 1: all active, no returns -> 0..7,0..7 then idle
        doReset();
        checkConst("t1_reset_valid", int'(fetchValid_o), 0);
        checkConst("t1_reset_err", int'(creditErr_o), 0);
        warpActive = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            cyc("t1_grant");
            checkConst("t1_seq", int'(fetchWarp_o), i % 8);
        end
        cyc("t1_exhaust");
        checkConst("t1_exhaust_valid", int'(fetchValid_o), 0);

        // 2: warps 2 and 5, returning every cycle -> 2,5,2,5
        doReset();
        warpActive = 8'b0010_0100;
        for (int i = 0; i < 10; i++) begin
            creditRet = mValid; creditWarp = mWarp;
            cyc("t2_alt");
            checkConst("t2_seq", int'(fetchWarp_o), (i % 2 == 0) ? 2 : 5);
        end
        creditRet = 0;

        // 3: stall three cycles while warp 4 is presented
        doReset();
        warpActive = 8'hFF;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            creditRet = mValid; creditWarp = mWarp;
            cyc("t3_run");
            if (mValid && mWarp == 3'd4) found = 1;
        end
        checkConst("t3_reach4", int'(found), 1);
        creditRet = 0;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc("t3_stall");
            checkConst("t3_hold4", int'(fetchWarp_o), 4);
        end
        stall = 0;
        cyc("t3_resume");
        checkConst("t3_resume5", int'(fetchWarp_o), 5);

        // 4: block warp 3, then flush it together with a credit return
        doReset();
        warpActive = 8'h08;
        cyc("t4_first");
        block = 1; blockWarp = 3;
        cyc("t4_block");
        block = 0;
        cyc("t4_blocked");
        checkConst("t4_blocked_valid", int'(fetchValid_o), 0);
        flush = 1; flushWarp = 3; creditRet = 1; creditWarp = 3;
        cyc("t4_flush");
        flush = 0; creditRet = 0;
        cyc("t4_regrant");
        checkConst("t4_regrant3", int'(fetchValid_o), 1);
        cyc("t4_second");
        cyc("t4_empty");
        checkConst("t4_credit2_only", int'(fetchValid_o), 0);

        // 5: return at full credit -> sticky error
        doReset();
        warpActive = 8'h00;
        creditRet = 1; creditWarp = 1;
        cyc("t5_err");
        creditRet = 0;
        checkConst("t5_err_set", int'(creditErr_o), 1);
        warpActive = 8'h02;
        for (int i = 0; i < 4; i++) cyc("t5_sticky");
        checkConst("t5_err_sticky", int'(creditErr_o), 1);
        doReset();
        checkConst("t5_err_cleared", int'(creditErr_o), 0);

        // 6: reset in the middle of continuous grants
        warpActive = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            creditRet = mValid; creditWarp = mWarp;
            cyc("t6_run");
        end
        creditRet = 0;
        reset = 1;
        cyc("t6_reset");
        checkConst("t6_valid0", int'(fetchValid_o), 0);
        reset = 0;
        cyc("t6_first");
        checkConst("t6_first0", int'(fetchWarp_o), 0);

        // Randomized phase
        doReset();
        for (int i = 0; i < 400; i++) begin
            int rw;
            reset      = ($urandom_range(0, 99) == 0);
            warpActive = 8'($urandom) | 8'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            creditRet  = ($urandom_range(0, 1) == 1);
            rw         = $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (mCred[(rw + k) % 8] < 2) begin rw = (rw + k) % 8; break; end
                end
            end
            creditWarp = 3'(rw);
            block      = ($urandom_range(0, 19) == 0);
            blockWarp  = 3'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 11) == 0);
            flushWarp  = ($urandom_range(0, 1) == 1) ? mWarp : 3'($urandom_range(0, 7));
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
